// File: rtl/packet_dispatcher.sv
// packet_dispatcher: routes decoded HDMI data island packets by HB0 into an audio FIFO, ACR capture and InfoFrame capture.
// Optional macro SAMPLE_FLAT_MUTE_EN: pushed samples with their sample_flat bit set are written as silence.
module packet_dispatcher #(
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int AUDIO_FIFO_DEPTH = 8
) (
    input  logic                            clk_pixel,
    input  logic                            reset,
    input  logic                            packet_valid,
    input  logic                            packet_error,
    input  logic [23:0]                     header,
    input  logic [3:0][55:0]                sub,
    input  logic                            video_field_end,
    output logic                            audio_valid,
    input  logic                            audio_ready,
    output logic [1:0][AUDIO_BIT_WIDTH-1:0] audio_sample_word,
    output logic                            audio_block_start,
    output logic                            audio_overflow,
    output logic                            acr_valid,
    output logic [19:0]                     acr_n,
    output logic [19:0]                     acr_cts,
    output logic [6:0]                      avi_vic,
    output logic [2:0]                      audio_if_cc,
    output logic                            avi_timeout,
    output logic [7:0]                      drop_count
);
    localparam logic [1:0] IDLE = 2'd0, UNPACK = 2'd1, CHECKSUM = 2'd2, COMMIT = 2'd3;
    localparam int AW = $clog2(AUDIO_FIFO_DEPTH);
    localparam int EW = 2 * AUDIO_BIT_WIDTH + 1;
    logic [1:0] state_q, state_d, slot, fc_q, fc_d;
    logic [4:0] idx_q;
    logic [7:0] sum_q, drop_q, drop_d, hb0;
    logic [8:0] drop_sum;
    logic [23:0] hdr_q;
    logic [3:0][55:0] sub_q;
    logic [31:0][7:0] bytes_w;
    logic [EW-1:0] mem_q [AUDIO_FIFO_DEPTH];
    logic [EW-1:0] entry, head;
    logic [AW:0] wp_q, rp_q;
    logic is_if, take, drop_in, bad_sum, good_avi, push, pop, full, acc;
    logic ovf_q, acr_valid_q;
    logic [19:0] acr_n_q, acr_cts_q;
    logic [6:0] vic_q;
    logic [2:0] cc_q;
    // Checksum byte stream: HB0..HB2 followed by PB0..PB27 in subpacket order.
    always_comb begin
        bytes_w = '0;
        bytes_w[2:0] = hdr_q;
        for (int k = 0; k < 4; k++)
            for (int b = 0; b < 7; b++)
                bytes_w[3 + 7 * k + b] = sub_q[k][8 * b +: 8];
        slot = idx_q[1:0];
        hb0 = header[7:0];
        is_if = hb0 == 8'h82 || hb0 == 8'h84;
        take = packet_valid && state_q == IDLE && !packet_error && !(is_if && header[20:16] > 5'd27);
        drop_in = packet_valid && !take;
        bad_sum = state_q == COMMIT && sum_q != 8'd0;
        good_avi = state_q == COMMIT && sum_q == 8'd0 && hdr_q[7:0] == 8'h82;
        drop_sum = {1'b0, drop_q} + {8'd0, drop_in} + {8'd0, bad_sum};
        drop_d = drop_sum[8] ? 8'hff : drop_sum[7:0];
        fc_d = good_avi ? 2'd0 : (video_field_end && fc_q != 2'd2) ? fc_q + 2'd1 : fc_q;
        state_d = state_q == IDLE ? (take && hb0 == 8'h02 ? UNPACK : take && is_if ? CHECKSUM : IDLE)
                : state_q == UNPACK ? (slot == 2'd3 ? IDLE : UNPACK)
                : state_q == CHECKSUM ? (idx_q == hdr_q[20:16] + 5'd3 ? COMMIT : CHECKSUM)
                : IDLE;
        full = (wp_q ^ rp_q) == {1'b1, {AW{1'b0}}};
        pop = audio_valid && audio_ready;
        push = state_q == UNPACK && hdr_q[{3'b010, slot}];
        acc = push && (!full || pop);
        entry = {hdr_q[{3'b101, slot}], sub_q[slot][47 -: AUDIO_BIT_WIDTH], sub_q[slot][23 -: AUDIO_BIT_WIDTH]};
`ifdef SAMPLE_FLAT_MUTE_EN
        if (hdr_q[{3'b100, slot}]) entry[EW-2:0] = '0;
`else
`endif
        head = mem_q[rp_q[AW-1:0]];
    end
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q <= '0;
            sum_q <= '0;
            hdr_q <= '0;
            sub_q <= '0;
            wp_q <= '0;
            rp_q <= '0;
            ovf_q <= 1'b0;
            acr_valid_q <= 1'b0;
            acr_n_q <= '0;
            acr_cts_q <= '0;
            vic_q <= '0;
            cc_q <= '0;
            fc_q <= '0;
            drop_q <= '0;
        end else begin
            state_q <= state_d;
            drop_q <= drop_d;
            fc_q <= fc_d;
            acr_valid_q <= take && hb0 == 8'h01;
            if (take && hb0 == 8'h01) begin
                acr_cts_q <= {sub[0][11:8], sub[0][23:16], sub[0][31:24]};
                acr_n_q <= {sub[0][35:32], sub[0][47:40], sub[0][55:48]};
            end
            if (state_q == IDLE) begin
                idx_q <= '0;
                sum_q <= '0;
                if (take) begin
                    hdr_q <= header;
                    sub_q <= sub;
                end
            end else if (state_q != COMMIT) begin
                idx_q <= idx_q + 5'd1;
                sum_q <= sum_q + bytes_w[idx_q];
            end
            if (state_q == COMMIT && sum_q == 8'd0) begin
                if (hdr_q[7:0] == 8'h82) vic_q <= bytes_w[7][6:0];
                else cc_q <= bytes_w[4][2:0];
            end
            if (acc) wp_q <= wp_q + 1'b1;
            if (push && !acc) ovf_q <= 1'b1;
            if (pop) rp_q <= rp_q + 1'b1;
        end
    end
    always_ff @(posedge clk_pixel) begin
        if (acc) mem_q[wp_q[AW-1:0]] <= entry;
    end
    assign audio_valid = wp_q != rp_q;
    assign audio_sample_word = audio_valid ? head[EW-2:0] : '0;
    assign audio_block_start = audio_valid && head[EW-1];
    assign audio_overflow = ovf_q;
    assign acr_valid = acr_valid_q;
    assign acr_n = acr_n_q;
    assign acr_cts = acr_cts_q;
    assign avi_vic = vic_q;
    assign audio_if_cc = cc_q;
    assign avi_timeout = fc_q == 2'd2;
    assign drop_count = drop_q;
endmodule

// File: tb/tb_packet_dispatcher.sv
// tb_packet_dispatcher: randomized and directed stimulus checked every cycle against a schedule-based model.
module tb_packet_dispatcher;
    localparam int W = 16;
    localparam int D = 8;
    logic clk_pixel = 1'b0;
    logic reset = 1'b1;
    logic packet_valid = 1'b0;
    logic packet_error = 1'b0;
    logic [23:0] header = '0;
    logic [3:0][55:0] sub = '0;
    logic video_field_end = 1'b0;
    logic audio_ready = 1'b0;
    logic audio_valid, audio_block_start, audio_overflow, acr_valid, avi_timeout;
    logic [1:0][W-1:0] audio_sample_word;
    logic [19:0] acr_n, acr_cts;
    logic [6:0] avi_vic;
    logic [2:0] audio_if_cc;
    logic [7:0] drop_count;

    packet_dispatcher #(.AUDIO_BIT_WIDTH(W), .AUDIO_FIFO_DEPTH(D)) dut (
        .clk_pixel(clk_pixel), .reset(reset), .packet_valid(packet_valid), .packet_error(packet_error),
        .header(header), .sub(sub), .video_field_end(video_field_end), .audio_valid(audio_valid),
        .audio_ready(audio_ready), .audio_sample_word(audio_sample_word), .audio_block_start(audio_block_start),
        .audio_overflow(audio_overflow), .acr_valid(acr_valid), .acr_n(acr_n), .acr_cts(acr_cts),
        .avi_vic(avi_vic), .audio_if_cc(audio_if_cc), .avi_timeout(avi_timeout), .drop_count(drop_count)
    );

    always #5 clk_pixel = ~clk_pixel;

    typedef struct { int t; logic [2*W:0] e; } push_t;
    push_t pend[$];
    logic [2*W:0] mq[$];
    int tests = 0, fails = 0;
    int cyc = 0, next_free = 0, commit_t = -1, m_fc = 0, m_drop = 0;
    bit commit_ok, m_ovf, m_acrv;
    logic [7:0] commit_type;
    logic [6:0] commit_vic, m_vic;
    logic [2:0] commit_cc, m_cc;
    logic [19:0] m_n, m_cts;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, a, e);
        end
    endtask

    function automatic logic [7:0] pkt_byte(input logic [23:0] h, input logic [3:0][55:0] s, input int i);
        if (i < 3) return h[8 * i +: 8];
        return s[(i - 3) / 7][8 * ((i - 3) % 7) +: 8];
    endfunction

    function automatic void drop_inc();
        m_drop = m_drop < 255 ? m_drop + 1 : 255;
    endfunction

    // Model: each accepted packet schedules its future effects by absolute edge number.
    task automatic model_edge();
        logic [7:0] hb0, s;
        int len;
        bit isif, adv;
        push_t pe;
        cyc++;
        if (reset) begin
            mq.delete();
            pend.delete();
            commit_t = -1;
            next_free = cyc + 1;
            m_ovf = 0; m_acrv = 0; m_n = '0; m_cts = '0; m_vic = '0; m_cc = '0; m_fc = 0; m_drop = 0;
            return;
        end
        m_acrv = 0;
        if (mq.size() > 0 && audio_ready) void'(mq.pop_front());
        if (pend.size() > 0 && pend[0].t == cyc) begin
            pe = pend.pop_front();
            if (mq.size() < D) mq.push_back(pe.e);
            else m_ovf = 1;
        end
        adv = 0;
        if (commit_t == cyc) begin
            if (!commit_ok) drop_inc();
            else if (commit_type == 8'h82) begin m_vic = commit_vic; adv = 1; end
            else m_cc = commit_cc;
        end
        if (adv) m_fc = 0;
        else if (video_field_end && m_fc < 2) m_fc++;
        if (packet_valid) begin
            hb0 = header[7:0];
            len = int'(header[20:16]);
            isif = hb0 == 8'h82 || hb0 == 8'h84;
            if (cyc < next_free || packet_error || (isif && len > 27)) drop_inc();
            else if (hb0 == 8'h01) begin
                m_acrv = 1;
                m_cts = {sub[0][11:8], sub[0][23:16], sub[0][31:24]};
                m_n = {sub[0][35:32], sub[0][47:40], sub[0][55:48]};
            end else if (hb0 == 8'h02) begin
                for (int k = 0; k < 4; k++) if (header[8 + k]) begin
                    pe.t = cyc + 1 + k;
                    pe.e = {header[20 + k], sub[k][47 -: W], sub[k][23 -: W]};
`ifdef SAMPLE_FLAT_MUTE_EN
                    if (header[16 + k]) pe.e[2*W-1:0] = '0;
`else
`endif
                    pend.push_back(pe);
                end
                next_free = cyc + 5;
            end else if (isif) begin
                s = 8'd0;
                for (int i = 0; i < len + 4; i++) s = s + pkt_byte(header, sub, i);
                commit_ok = s == 8'd0;
                commit_t = cyc + len + 5;
                next_free = cyc + len + 6;
                commit_type = hb0;
                commit_vic = sub[0][38:32];
                commit_cc = sub[0][10:8];
            end
        end
    endtask

    task automatic check_all();
        logic [2*W:0] h;
        chk("audio_valid", 64'(audio_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            h = mq[0];
            chk("audio_word", 64'(audio_sample_word), 64'(h[2*W-1:0]));
            chk("audio_block_start", 64'(audio_block_start), 64'(h[2*W]));
        end
        chk("audio_overflow", 64'(audio_overflow), 64'(m_ovf));
        chk("acr_valid", 64'(acr_valid), 64'(m_acrv));
        chk("acr_n", 64'(acr_n), 64'(m_n));
        chk("acr_cts", 64'(acr_cts), 64'(m_cts));
        chk("avi_vic", 64'(avi_vic), 64'(m_vic));
        chk("audio_if_cc", 64'(audio_if_cc), 64'(m_cc));
        chk("avi_timeout", 64'(avi_timeout), 64'(m_fc == 2));
        chk("drop_count", 64'(drop_count), 64'(m_drop));
    endtask

    task automatic step();
        @(posedge clk_pixel);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic send();
        packet_valid = 1'b1;
        step();
        packet_valid = 1'b0;
        packet_error = 1'b0;
    endtask

    function automatic void fix_sum(input bit good);
        logic [7:0] s;
        s = 8'd0;
        for (int i = 0; i < int'(header[20:16]) + 4; i++) if (i != 3) s = s + pkt_byte(header, sub, i);
        sub[0][7:0] = good ? 8'(8'd0 - s) : ~8'(8'd0 - s);
    endfunction

    task automatic prep_avi(input logic [6:0] vic, input bit good);
        header = {3'b000, 5'd13, 8'h02, 8'h82};
        sub = '0;
        sub[0][39:32] = {1'b0, vic};
        fix_sum(good);
    endtask

    task automatic rand_packet();
        logic [7:0] types [6];
        int len;
        types = '{8'h00, 8'h01, 8'h02, 8'h82, 8'h84, 8'h33};
        for (int k = 0; k < 4; k++) sub[k] = 56'({$urandom(), $urandom()});
        header = 24'($urandom());
        header[7:0] = types[$urandom_range(0, 5)];
        packet_error = $urandom_range(0, 15) == 0;
        if (header[7:0] == 8'h82 || header[7:0] == 8'h84) begin
            len = $urandom_range(0, 9) == 0 ? $urandom_range(28, 31) : $urandom_range(0, 27);
            header[20:16] = 5'(len);
            fix_sum($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        int n;
        logic [7:0] kb;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("reset_audio_valid", 64'(audio_valid), 64'd0);
        chk("reset_drop", 64'(drop_count), 64'd0);
        chk("reset_vic", 64'(avi_vic), 64'd0);
        // ACR: N = 6144, CTS = 74250
        sub = '0;
        sub[0] = 56'h00_18_00_0A_22_01_00;
        header = 24'h000001;
        send();
        chk("acr_pulse", 64'(acr_valid), 64'd1);
        chk("acr_n_lit", 64'(acr_n), 64'd6144);
        chk("acr_cts_lit", 64'(acr_cts), 64'd74250);
        step();
        chk("acr_pulse_end", 64'(acr_valid), 64'd0);
        // Four-sample audio packet, block start on slot 0 only
        audio_ready = 1'b1;
        header = 24'h100F02;
        for (int k = 0; k < 4; k++) begin
            kb = 8'(k);
            sub[k] = {8'h00, 8'h44 + kb, 8'h55, 8'h66, 8'h11 * (kb + 8'd1), 8'h22, 8'h33};
        end
        send();
        for (int k = 0; k < 4; k++) begin
            kb = 8'(k);
            step();
            chk("aud_valid_lit", 64'(audio_valid), 64'd1);
            chk("aud_word_lit", 64'(audio_sample_word), 64'({8'h44 + kb, 8'h55, 8'h11 * (kb + 8'd1), 8'h22}));
            chk("aud_bs_lit", 64'(audio_block_start), 64'(k == 0));
        end
        step();
        chk("aud_drained", 64'(audio_valid), 64'd0);
        // Fill the FIFO with the consumer stalled, then overflow it
        audio_ready = 1'b0;
        header = 24'h000302;
        for (int k = 0; k < 4; k++) sub[k] = 56'({$urandom(), $urandom()});
        repeat (3) begin
            send();
            repeat (4) step();
        end
        chk("ovf_before", 64'(audio_overflow), 64'd0);
        header = 24'h000F02;
        send();
        repeat (4) step();
        chk("ovf_after", 64'(audio_overflow), 64'd1);
        n = 0;
        audio_ready = 1'b1;
        while (audio_valid && n < 20) begin
            step();
            n++;
        end
        chk("fifo_fill", 64'(n), 64'd8);
        // AVI InfoFrame: good then corrupted checksum
        prep_avi(7'd16, 1'b1);
        send();
        repeat (17) step();
        chk("avi_early", 64'(avi_vic), 64'd0);
        step();
        chk("avi_commit", 64'(avi_vic), 64'd16);
        chk("avi_nodrop", 64'(drop_count), 64'd0);
        prep_avi(7'd5, 1'b0);
        send();
        repeat (18) step();
        chk("avi_bad_vic", 64'(avi_vic), 64'd16);
        chk("avi_bad_drop", 64'(drop_count), 64'd1);
        // A packet arriving while busy is dropped; the InfoFrame still commits
        prep_avi(7'd4, 1'b1);
        send();
        step();
        header = 24'h000001;
        send();
        repeat (16) step();
        chk("busy_vic", 64'(avi_vic), 64'd4);
        chk("busy_drop", 64'(drop_count), 64'd2);
        step();
        header = {3'b000, 5'd28, 8'h02, 8'h84};
        send();
        chk("len28_drop", 64'(drop_count), 64'd3);
        header = 24'h000033;
        send();
        header = 24'h000000;
        send();
        chk("unknown_nodrop", 64'(drop_count), 64'd3);
        header = 24'h000001;
        packet_error = 1'b1;
        send();
        chk("err_drop", 64'(drop_count), 64'd4);
        chk("err_no_acr", 64'(acr_valid), 64'd0);
        // Field timeout, then commit racing a field end
        video_field_end = 1'b1;
        step();
        step();
        video_field_end = 1'b0;
        chk("timeout_set", 64'(avi_timeout), 64'd1);
        prep_avi(7'd16, 1'b1);
        send();
        repeat (17) step();
        video_field_end = 1'b1;
        step();
        video_field_end = 1'b0;
        chk("timeout_clr", 64'(avi_timeout), 64'd0);
        chk("timeout_vic", 64'(avi_vic), 64'd16);
        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            audio_ready = $urandom_range(0, 3) != 0;
            video_field_end = $urandom_range(0, 40) == 0;
            reset = $urandom_range(0, 500) == 0;
            packet_valid = $urandom_range(0, 5) == 0;
            packet_error = 1'b0;
            if (packet_valid) rand_packet();
            step();
        end
        reset = 1'b0;
        packet_valid = 1'b0;
        packet_error = 1'b0;
        video_field_end = 1'b0;
        // Saturation of the drop counter
        header = 24'h000001;
        repeat (300) begin
            packet_error = 1'b1;
            send();
        end
        chk("drop_saturate", 64'(drop_count), 64'd255);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/packet_dispatcher.md
Name: packet_dispatcher

Overview:
- Receive-side counterpart of the transmit packet selection: consumes decoded, ECC-checked HDMI data island packets and routes them by packet type (HB0).
- Unpacks Audio Sample packets (0x02) into an audio FIFO; captures ACR N/CTS (0x01); checksum-verifies and captures AVI (0x82) and Audio (0x84) InfoFrames.
- Sits after the TERC4 decoder / BCH checker in the clk_pixel domain, feeding the audio output and the receiver status logic.

Parameters:
- AUDIO_BIT_WIDTH, 16, output sample width; MSBs of each 24-bit received word (bits 23 down to 24-AUDIO_BIT_WIDTH); legal 16..24.
- AUDIO_FIFO_DEPTH, 8, FIFO entries (stereo pairs); power of two, >= 4.

Ports:
- clk_pixel  input  1  pixel clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- packet_valid  input  1  one-cycle strobe; header/sub valid this cycle.
- packet_error  input  1  upstream BCH uncorrectable flag, qualified by packet_valid.
- header  input  24  HB0 in [7:0], HB1 in [15:8], HB2 in [23:16].
- sub  input  4x56  subpacket k byte b at sub[k][8b+7:8b].
- video_field_end  input  1  one-cycle pulse at the end of each video field.
- audio_valid  output  1  FIFO not empty.
- audio_ready  input  1  consumer accepts the head entry when audio_valid && audio_ready.
- audio_sample_word  output  2xAUDIO_BIT_WIDTH  [0]=left, [1]=right.
- audio_block_start  output  1  head sample carries the IEC 60958 block-start (B) flag.
- audio_overflow  output  1  sticky; a sample was dropped because the FIFO was full.
- acr_valid  output  1  one-cycle pulse when acr_n/acr_cts update.
- acr_n  output  20  captured N.
- acr_cts  output  20  captured CTS.
- avi_vic  output  7  last valid AVI VIC, from PB4[6:0].
- audio_if_cc  output  3  last valid Audio InfoFrame channel count, from PB1[2:0].
- avi_timeout  output  1  no valid AVI InfoFrame within two fields.
- drop_count  output  8  saturating count of dropped packets.

Behaviour:
- Reset: every output 0; FIFO empty; FSM in IDLE; field counter 0. Reset mid-operation aborts any packet in progress; its partial effects are discarded except samples already pushed, which are also flushed.
- FSM states: IDLE, UNPACK, CHECKSUM, COMMIT. packet_valid is sampled only in IDLE.
- Drop rule: packet_valid when not in IDLE, packet_error=1, or InfoFrame length HB2[4:0] > 27 -> packet ignored and drop_count incremented (saturates at 255).
- HB0 0x00 and unknown types are ignored and are not counted as drops.
- ACR (0x01), from subpacket 0:
  - CTS = {SB1[3:0], SB2, SB3}; N = {SB4[3:0], SB5, SB6}.
  - Registered on the edge that samples packet_valid; acr_valid pulses the following cycle. FSM stays in IDLE.
- Audio Sample (0x02), captured on the packet_valid edge; FSM goes to UNPACK.
  - UNPACK visits slot k=0..3 on consecutive cycles, always 4 cycles, then returns to IDLE.
  - Slot k is pushed iff sample_present HB1[k]=1.
  - Entry: left = sub[k][23:0] truncated; right = sub[k][47:24] truncated; block_start = HB2[4+k].
  - If the FIFO is full when slot k is visited, the sample is dropped and audio_overflow is set. audio_overflow clears only on reset.
  - HB1[4] (layout 1) packets are treated as layout 0.
- FIFO:
  - Push and pop in the same cycle are both honoured, including when full (the pop frees the slot).
  - audio_sample_word and audio_block_start are the head entry and are held stable while audio_valid && !audio_ready.
- InfoFrame (0x82, 0x84): capture, then CHECKSUM accumulates one byte per cycle.
  - Bytes summed: HB0, HB1, HB2, PB0..PB(length), so n = length+4 bytes.
  - PB0..PB6 = sub[0] bytes 0..6; PB7..PB13 = sub[1] bytes 0..6; and so on.
  - COMMIT: if the 8-bit sum == 0, update avi_vic or audio_if_cc; otherwise increment drop_count.
  - The output change is visible length+5 edges after the packet_valid edge.
- avi_timeout:
  - A 2-bit field counter increments on video_field_end (saturating at 2) and clears on a committed valid AVI.
  - avi_timeout = (counter == 2).
  - If a valid AVI commit and video_field_end occur in the same cycle, the commit wins and the counter becomes 0.

Optional Feature:
- Macro SAMPLE_FLAT_MUTE_EN.
- Defined: a pushed sample whose sample_flat bit HB2[k]=1 is written with left = right = 0; block_start is kept.
- Undefined: the flat bits are ignored and raw sample data is pushed.

Test Plan:
- ACR packet with N=6144, CTS=74250 -> acr_valid pulses 1 cycle later; acr_n=6144, acr_cts=74250.
- Audio packet with HB1=0x0F, HB2=0x10, audio_ready=1 -> 4 entries appear in order; only the first has audio_block_start=1; values are the 24-bit words truncated to 16 MSBs.
- audio_ready=0, three packets with HB1=0x03 (6 samples) into an 8-deep FIFO, then a fourth packet with HB1=0x0F -> 2 samples accepted, 2 dropped; audio_overflow=1; FIFO holds 8 entries.
- AVI packet, length 13, VIC=16, correct checksum -> avi_vic=16 after 18 edges. Same packet with a corrupted checksum -> avi_vic unchanged and drop_count +1.
- Second packet_valid 2 cycles into an AVI checksum -> second packet dropped (drop_count +1) and the first commits normally.
- Two video_field_end pulses with no AVI -> avi_timeout=1. A valid AVI arriving in the same cycle as the next video_field_end -> avi_timeout=0.
